// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional build macro MULDIV_EARLY_OUT_EN: special cases and multiply-by-zero finish in one cycle.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  src1_i,
    input  logic [XLEN-1:0]  src2_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam int unsigned ACC_W = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state_q, state_d;

    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  b_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_a_q, neg_r_q, special_q;
    logic [XLEN-1:0]  special_res_q;

    logic             accept_c, early_c;
    logic             sgn1_c, sgn2_c, s1_c, s2_c;
    logic [XLEN-1:0]  mag1_c, mag2_c;
    logic             div_zero_c, ovf_c, special_c;
    logic [XLEN-1:0]  special_res_c;
    logic [ACC_W-1:0] acc_next_c;
    logic [XLEN-1:0]  fix_res_c;

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign accept_c    = in_valid_i & ~flush_i;

    // Operand signedness and magnitudes at the accept edge
    always_comb begin
        sgn1_c = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
        sgn2_c = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        s1_c   = sgn1_c & src1_i[XLEN-1];
        s2_c   = sgn2_c & src2_i[XLEN-1];
        mag1_c = s1_c ? (XLEN'(0) - src1_i) : src1_i;
        mag2_c = s2_c ? (XLEN'(0) - src2_i) : src2_i;
    end

    // Divide special cases and their architected results
    always_comb begin
        div_zero_c = op_i[2] & (src2_i == '0);
        ovf_c      = ((op_i == OP_DIV) || (op_i == OP_REM)) && (src1_i == INT_MIN) && (src2_i == '1);
        special_c  = div_zero_c | ovf_c;
        if (div_zero_c) begin
            special_res_c = op_i[1] ? src1_i : '1;
        end else begin
            special_res_c = op_i[1] ? '0 : INT_MIN;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign early_c = special_c | (~op_i[2] & (src2_i == '0));
`else
    assign early_c = 1'b0;
`endif

    // One iteration: multiply adds then shifts right; divide shifts left and trial-subtracts
    always_comb begin
        logic [XLEN:0]   sum;
        logic [XLEN:0]   trial;
        logic [XLEN-1:0] new_rem;
        logic            qbit;
        sum     = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        trial   = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]} - {1'b0, b_q};
        qbit    = ~trial[XLEN];
        new_rem = qbit ? trial[XLEN-1:0] : acc_q[ACC_W-2:XLEN-1];
        if (op_q[2]) begin
            acc_next_c = {new_rem, acc_q[XLEN-2:0], qbit};
        end else begin
            acc_next_c = {sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction and result selection in FIX
    always_comb begin
        logic [ACC_W-1:0] prod;
        logic [XLEN-1:0]  quo;
        logic [XLEN-1:0]  rem;
        prod = neg_a_q ? (ACC_W'(0) - acc_q) : acc_q;
        quo  = neg_a_q ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem  = neg_r_q ? (XLEN'(0) - acc_q[ACC_W-1:XLEN]) : acc_q[ACC_W-1:XLEN];
        if (special_q) begin
            fix_res_c = special_res_q;
        end else if (!op_q[2]) begin
            fix_res_c = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[ACC_W-1:XLEN];
        end else begin
            fix_res_c = op_q[1] ? rem : quo;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept_c) state_d = early_c ? DONE : CALC;
            CALC: begin
                if (flush_i)                           state_d = IDLE;
                else if (cnt_q == CNT_W'(XLEN - 1))    state_d = FIX;
            end
            FIX:  state_d = flush_i ? IDLE : DONE;
            DONE: if (flush_i || out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q          <= '0;
            tag_q         <= '0;
            b_q           <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            neg_a_q       <= 1'b0;
            neg_r_q       <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            result_o      <= '0;
            tag_o         <= '0;
        end else begin
            if (state_q == IDLE && accept_c) begin
                op_q          <= op_i;
                tag_q         <= tag_i;
                b_q           <= op_i[2] ? mag2_c : mag1_c;
                acc_q         <= {{XLEN{1'b0}}, (op_i[2] ? mag1_c : mag2_c)};
                cnt_q         <= '0;
                neg_a_q       <= s1_c ^ s2_c;
                neg_r_q       <= s1_c;
                special_q     <= special_c;
                special_res_q <= special_res_c;
                if (early_c) begin
                    result_o <= special_c ? special_res_c : '0;
                    tag_o    <= tag_i;
                end
            end
            if (state_q == CALC) begin
                acc_q <= acc_next_c;
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == FIX && !flush_i) begin
                result_o <= fix_res_c;
                tag_o    <= tag_q;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam int TW   = 5;
    localparam int FULL_LAT = XLEN + 2;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = FULL_LAT;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op = '0;
    logic [XLEN-1:0] src1 = '0;
    logic [XLEN-1:0] src2 = '0;
    logic [TW-1:0]   tag = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic [TW-1:0]   tag_out;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [TW-1:0]   tag;
        logic [7:0]      lat;
    } exp_t;
    exp_t sb[$];

    int n_pass = 0;
    int n_total = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TW)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .src1_i(src1), .src2_i(src2), .tag_i(tag), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result), .tag_o(tag_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    // Drive one request for a cycle; caller sits on a negedge
    task automatic send(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TW-1:0] t);
        in_valid = 1'b1; op = o; src1 = a; src2 = b; tag = t;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic issue(input string name, input logic [2:0] o, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TW-1:0] t,
                         input logic [XLEN-1:0] r, input int lat);
        check({name, "_ready"}, 64'(in_ready), 64'd1);
        sb.push_back('{res: r, tag: t, lat: 8'(lat)});
        send(o, a, b, t);
    endtask

    task automatic wait_result(input string name, output logic [XLEN-1:0] r, output logic [TW-1:0] t);
        int cyc = 1;
        exp_t e;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        r = e.res;
        t = e.tag;
        check({name, "_lat"}, 64'(cyc), 64'(e.lat));
        check({name, "_res"}, 64'(result), 64'(e.res));
        check({name, "_tag"}, 64'(tag_out), 64'(e.tag));
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_vdrop"}, 64'(out_valid), 64'd0);
        check({name, "_rdy"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TW-1:0] t,
                       input logic [XLEN-1:0] r, input int lat);
        logic [XLEN-1:0] er;
        logic [TW-1:0]   et;
        issue(name, o, a, b, t, r, lat);
        wait_result(name, er, et);
        handshake(name);
    endtask

    task automatic quiet(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [XLEN-1:0] er;
        logic [TW-1:0]   et;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_tag", 64'(tag_out), 64'd0);

        run("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, FULL_LAT);
        run("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, FULL_LAT);
        run("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, FULL_LAT);
        run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, FULL_LAT);

        run("div",  3'd4, 32'hFFFFFFF9, 32'd2, 5'h13, 32'hFFFFFFFD, FULL_LAT);
        run("rem",  3'd6, 32'hFFFFFFF9, 32'd2, 5'h13, 32'hFFFFFFFF, FULL_LAT);
        run("divu", 3'd5, 32'd100,      32'd7, 5'h13, 32'd14,       FULL_LAT);
        run("remu", 3'd7, 32'd100,      32'd7, 5'h0A, 32'd2,        FULL_LAT);

        run("div0",   3'd4, 32'd5,        32'd0,        5'd6, 32'hFFFFFFFF, SPEC_LAT);
        run("rem0",   3'd6, 32'd5,        32'd0,        5'd7, 32'd5,        SPEC_LAT);
        run("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h80000000, SPEC_LAT);
        run("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'd0,        SPEC_LAT);

        // Backpressure: result held, new request ignored
        issue("bp", 3'd5, 32'd100, 32'd7, 5'h15, 32'd14, FULL_LAT);
        wait_result("bp", er, et);
        in_valid = 1'b1; op = 3'd0; src1 = 32'd1; src2 = 32'd1; tag = 5'h1F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_res", 64'(result), 64'(er));
            check("bp_hold_tag", 64'(tag_out), 64'(et));
            check("bp_hold_rdy", 64'(in_ready), 64'd0);
            check("bp_hold_vld", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        handshake("bp");
        quiet("bp_no_extra", 40);

        // Flush in the 10th CALC cycle
        send(3'd0, 32'd5, 32'd6, 5'd2);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", 64'(in_ready), 64'd1);
        quiet("flush_no_out", 40);
        run("post_flush", 3'd5, 32'd9, 32'd3, 5'd11, 32'd3, FULL_LAT);

        // Flush with request in IDLE blocks acceptance
        flush = 1'b1;
        send(3'd5, 32'd9, 32'd3, 5'd12);
        flush = 1'b0;
        check("flush_idle_rdy", 64'(in_ready), 64'd1);
        quiet("flush_idle_none", 40);

        // Reset during CALC
        send(3'd0, 32'd9, 32'd9, 5'd14);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_result", 64'(result), 64'd0);
        check("mrst_tag", 64'(tag_out), 64'd0);
        check("mrst_ready", 64'(in_ready), 64'd1);
        quiet("mrst_no_out", 40);
        run("post_rst", 3'd0, 32'd3, 32'd4, 5'd3, 32'd12, FULL_LAT);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
